// File: rtl/as_input_arbiter_pkg.sv
// Shared types and constants for the packet-granular round-robin input arbiter.
package as_input_arbiter_pkg;

    localparam int DATA_WIDTH_DEF = 64;
    localparam int NUM_QUEUES_DEF = 4;

    // First module header of every packet carries this ctrl value.
    localparam logic [7:0] IO_QUEUE_STAGE_NUM = 8'hff;

    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        IN_HDR = 3'b010,
        IN_PKT = 3'b100
    } arb_state_e;

    function automatic int rr_next(input int cur, input int n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/as_input_arbiter_if.sv
// Input-FIFO side and parser side of the arbiter, bundled as one bus.
interface as_input_arbiter_if
    import as_input_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_QUEUES = NUM_QUEUES_DEF
);
    localparam int CTRL_WIDTH = DATA_WIDTH / 8;

    logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data;
    logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl;
    logic [NUM_QUEUES-1:0]            in_empty;
    logic [NUM_QUEUES-1:0]            in_rd_en;
    logic [DATA_WIDTH-1:0]            out_data;
    logic [CTRL_WIDTH-1:0]            out_ctrl;
    logic                             out_wr;
    logic                             out_rdy;

    modport master (
        input  in_data, in_ctrl, in_empty, out_rdy,
        output in_rd_en, out_data, out_ctrl, out_wr
    );

    modport slave (
        output in_data, in_ctrl, in_empty, out_rdy,
        input  in_rd_en, out_data, out_ctrl, out_wr
    );

endinterface

// File: rtl/as_input_arbiter_rr_priority_select.sv
// Round-robin priority pick: first requesting queue at or after i_ptr, wrapping.
module as_input_arbiter_rr_priority_select #(
    parameter int NUM_QUEUES = 4,
    parameter int NUM_Q_BITS = $clog2(NUM_QUEUES)
) (
    input  logic [NUM_QUEUES-1:0] i_req,
    input  logic [NUM_Q_BITS-1:0] i_ptr,
    output logic                  o_found,
    output logic [NUM_Q_BITS-1:0] o_idx
);

    // Walk the rotated vector from the far end so the offset nearest i_ptr wins;
    // the rotated offset maps straight back to the absolute queue index.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
            int w_q;
            w_q = (i + int'(i_ptr)) % NUM_QUEUES;
            if (i_req[w_q[NUM_Q_BITS-1:0]]) begin
                o_found = 1'b1;
                o_idx   = w_q[NUM_Q_BITS-1:0];
            end
        end
    end

endmodule

// File: rtl/as_input_arbiter.sv
// Packet-granular round-robin arbiter draining NUM_QUEUES show-ahead FIFOs onto
// one datapath stream; a granted packet goes out whole before the next grant.
module as_input_arbiter
    import as_input_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_QUEUES = NUM_QUEUES_DEF,
    parameter int NUM_Q_BITS = $clog2(NUM_QUEUES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    as_input_arbiter_if.master    bus,
    output logic [NUM_Q_BITS-1:0] o_cur_queue,
    output logic [31:0]           o_pkts_fwd
);

    arb_state_e            r_state;
    logic [NUM_Q_BITS-1:0] r_cur_queue;
    logic [NUM_Q_BITS-1:0] r_rr_ptr;
    logic [31:0]           r_pkts_fwd;
    logic                  r_out_wr;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [CTRL_WIDTH-1:0] r_out_ctrl;

    logic                  w_found;
    logic [NUM_Q_BITS-1:0] w_idx;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic [CTRL_WIDTH-1:0] w_head_ctrl;
    logic                  w_head_is_body;

    as_input_arbiter_rr_priority_select #(
        .NUM_QUEUES (NUM_QUEUES),
        .NUM_Q_BITS (NUM_Q_BITS)
    ) u_rr_sel (
        .i_req   (~bus.in_empty),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    assign w_head_data    = bus.in_data[r_cur_queue*DATA_WIDTH +: DATA_WIDTH];
    assign w_head_ctrl    = bus.in_ctrl[r_cur_queue*CTRL_WIDTH +: CTRL_WIDTH];
    assign w_head_is_body = (w_head_ctrl == '0);

    // Popping is held off in IDLE, which costs one gap cycle per packet but keeps
    // the grant decision off the pop path.
    assign w_pop = (r_state != IDLE) && !bus.in_empty[r_cur_queue] && bus.out_rdy;

    always_comb begin
        bus.in_rd_en              = '0;
        bus.in_rd_en[r_cur_queue] = w_pop;
    end

    assign bus.out_wr   = r_out_wr;
    assign bus.out_data = r_out_data;
    assign bus.out_ctrl = r_out_ctrl;
    assign o_cur_queue  = r_cur_queue;
    assign o_pkts_fwd   = r_pkts_fwd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cur_queue <= '0;
            r_rr_ptr    <= '0;
            r_pkts_fwd  <= '0;
            r_out_wr    <= 1'b0;
            r_out_data  <= '0;
            r_out_ctrl  <= '0;
        end else begin
            r_out_wr <= w_pop;
            if (w_pop) begin
                r_out_data <= w_head_data;
                r_out_ctrl <= w_head_ctrl;
            end

            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_cur_queue <= w_idx;
                        r_state     <= IN_HDR;
                    end
                end
                IN_HDR: begin
                    if (w_pop && w_head_is_body)
                        r_state <= IN_PKT;
                end
                IN_PKT: begin
                    // First non-zero ctrl after the body is the last word.
                    if (w_pop && !w_head_is_body) begin
                        r_rr_ptr   <= NUM_Q_BITS'(rr_next(int'(r_cur_queue), NUM_QUEUES));
                        r_pkts_fwd <= r_pkts_fwd + 32'd1;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_as_input_arbiter.sv
// Directed bench: show-ahead FIFO stand-ins per queue, hand-built expected word streams.
module tb_as_input_arbiter;
    import as_input_arbiter_pkg::*;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int NQ = 4;
    localparam int QB = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    as_input_arbiter_if #(.DATA_WIDTH(DW), .NUM_QUEUES(NQ)) bus ();
    logic [QB-1:0] cur_queue;
    logic [31:0]   pkts_fwd;

    as_input_arbiter #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_QUEUES(NQ), .NUM_Q_BITS(QB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_cur_queue (cur_queue),
        .o_pkts_fwd  (pkts_fwd)
    );

    logic [71:0] fifo [NQ][$];
    logic [71:0] exp_q [$];
    logic [71:0] obs [$];
    int          obs_t [$];
    int          cyc = 0;
    int          viol = 0;
    logic        rdy_mode = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Word i of a packet with nb body words: header, body..., then EOP with ctrl 0x04.
    function automatic logic [71:0] mk(input int q, input int tag, input int i, input int nb);
        logic [63:0] d;
        d = {8'(q), 8'(tag), 48'(i)};
        if (i == 0)      return {IO_QUEUE_STAGE_NUM, d};
        if (i == nb + 1) return {8'h04, d};
        return {8'h00, d};
    endfunction

    task automatic pkt(input int q, input int nb, input int tag);
        for (int i = 0; i <= nb + 1; i++) begin
            fifo[q].push_back(mk(q, tag, i, nb));
            exp_q.push_back(mk(q, tag, i, nb));
        end
    endtask

    // FIFO pop on the same edge the DUT registers the head word.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            for (int q = 0; q < NQ; q++)
                if (bus.in_rd_en[q] && fifo[q].size() > 0) void'(fifo[q].pop_front());
            if ((|bus.in_rd_en && !bus.out_rdy) || $countones(bus.in_rd_en) > 1)
                viol <= viol + 1;
        end
    end

    // Capture outputs and present the new FIFO heads half a cycle after the edge.
    always @(negedge clk) begin
        if (rst_n && bus.out_wr) begin
            obs.push_back({bus.out_ctrl, bus.out_data});
            obs_t.push_back(cyc);
        end
        bus.out_rdy = rdy_mode ? ~bus.out_rdy : 1'b1;
        for (int q = 0; q < NQ; q++) begin
            if (fifo[q].size() > 0) begin
                bus.in_empty[q]            = 1'b0;
                bus.in_data[q*DW +: DW]    = fifo[q][0][63:0];
                bus.in_ctrl[q*CW +: CW]    = fifo[q][0][71:64];
            end else begin
                bus.in_empty[q]            = 1'b1;
                bus.in_data[q*DW +: DW]    = '0;
                bus.in_ctrl[q*CW +: CW]    = '0;
            end
        end
    end

    task automatic clear_all();
        for (int q = 0; q < NQ; q++) fifo[q].delete();
        exp_q.delete();
        obs.delete();
        obs_t.delete();
    endtask

    task automatic reset_all();
        rst_n    = 1'b0;
        rdy_mode = 1'b0;
        clear_all();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_pkts(input int n, input string tag);
        int b;
        b = 0;
        while (pkts_fwd != 32'(n) && b < 400) begin
            @(negedge clk);
            b++;
        end
        if (b >= 400) chk({tag, "_timeout"}, 72'(pkts_fwd), 72'(n));
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_obs(input int n, input string tag);
        int b;
        b = 0;
        while (obs.size() < n && b < 400) begin
            @(negedge clk);
            b++;
        end
        if (b >= 400) chk({tag, "_timeout"}, 72'(obs.size()), 72'(n));
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_cnt"}, 72'(obs.size()), 72'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), (i < obs.size()) ? obs[i] : 72'hx, exp_q[i]);
    endtask

    function automatic int gaps();
        if (obs_t.size() == 0) return -1;
        return obs_t[obs_t.size()-1] - obs_t[0] + 1 - obs_t.size();
    endfunction

    initial begin
        int v0;
        logic [71:0] q1w [$];

        // Single packet on q0.
        reset_all();
        pkt(0, 3, 2);
        wait_pkts(1, "t2");
        cmp_stream("t2");
        chk("t2_cur_queue", 72'(cur_queue), 72'd0);
        chk("t2_pkts", 72'(pkts_fwd), 72'd1);
        chk("t2_gaps", 72'(gaps()), 72'd0);

        // Asynchronous reset while q1 is mid-packet.
        clear_all();
        pkt(1, 10, 1);
        wait_obs(3, "t1");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_out_wr", 72'(bus.out_wr), 72'd0);
        chk("t1_rd_en", 72'(bus.in_rd_en), 72'd0);
        chk("t1_pkts", 72'(pkts_fwd), 72'd0);
        chk("t1_cur_queue", 72'(cur_queue), 72'd0);
        chk("t1_out_data", 72'(bus.out_data), 72'd0);
        clear_all();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        // Everything empty: nothing moves.
        repeat (10) @(negedge clk);
        chk("idle_obs", 72'(obs.size()), 72'd0);
        chk("idle_rd_en", 72'(bus.in_rd_en), 72'd0);
        chk("idle_pkts", 72'(pkts_fwd), 72'd0);

        // All four queues ready at once.
        reset_all();
        for (int q = 0; q < NQ; q++) pkt(q, 1, 3);
        wait_pkts(4, "t3");
        cmp_stream("t3");
        chk("t3_pkts", 72'(pkts_fwd), 72'd4);
        chk("t3_gaps", 72'(gaps()), 72'd3);
        chk("t3_cur_queue", 72'(cur_queue), 72'd3);

        // Back-pressure toggling every cycle.
        reset_all();
        v0 = viol;
        rdy_mode = 1'b1;
        pkt(1, 4, 4);
        wait_pkts(1, "t4");
        rdy_mode = 1'b0;
        cmp_stream("t4");
        chk("t4_viol", 72'(viol - v0), 72'd0);

        // q2 starves mid-packet while q1 waits.
        reset_all();
        for (int i = 0; i < 2; i++) begin
            fifo[2].push_back(mk(2, 5, i, 2));
            exp_q.push_back(mk(2, 5, i, 2));
        end
        wait_obs(2, "t5");
        for (int i = 0; i <= 3; i++) q1w.push_back(mk(1, 5, i, 2));
        foreach (q1w[i]) fifo[1].push_back(q1w[i]);
        repeat (5) @(negedge clk);
        chk("t5_hold_queue", 72'(cur_queue), 72'd2);
        chk("t5_stall_cnt", 72'(obs.size()), 72'd2);
        for (int i = 2; i <= 3; i++) begin
            fifo[2].push_back(mk(2, 5, i, 2));
            exp_q.push_back(mk(2, 5, i, 2));
        end
        foreach (q1w[i]) exp_q.push_back(q1w[i]);
        wait_pkts(2, "t5");
        cmp_stream("t5");
        chk("t5_cur_queue", 72'(cur_queue), 72'd1);

        // Sole requester q3, three packets; pointer wraps back to 0 each time.
        reset_all();
        pkt(3, 1, 6);
        pkt(3, 1, 7);
        pkt(3, 1, 8);
        wait_pkts(3, "t6");
        cmp_stream("t6");
        chk("t6_pkts", 72'(pkts_fwd), 72'd3);
        chk("t6_gaps", 72'(gaps()), 72'd2);
        chk("t6_cur_queue", 72'(cur_queue), 72'd3);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
